hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 123 ++++++++++++
 tb/tb_hazard_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand bypass selects, load-use and branch stalls,
// and a fixed-length stall window for multi-cycle multiply/divide.
module hazard_unit #(
  parameter int unsigned MD_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       branchD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic       regwriteE,
  input  logic       memtoregE,
  input  logic       mdstartE,
  input  logic [4:0] writeregM,
  input  logic       regwriteM,
  input  logic       memtoregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteW,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       mdbusy
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;

  logic lwstall;
  logic brstall;
  logic md_go;

  // Register 0 is hardwired, so it never counts as a dependency.
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  // Stall conditions and the IDLE-cycle multiply/divide launch.
  always_comb begin
    lwstall = memtoregE & (hit(rsD, writeregE) | hit(rtD, writeregE));
    brstall = branchD &
              ((regwriteE & (hit(rsD, writeregE) | hit(rtD, writeregE))) |
               (memtoregM & (hit(rsD, writeregM) | hit(rtD, writeregM))));
    md_go   = (state_q == StIdle) & mdstartE;
  end

  // Output decode; reset forces a bubble into EX and clears everything else.
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushE    = 1'b0;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    mdbusy    = 1'b0;
    if (reset) begin
      flushE = 1'b1;
    end else begin
      forwardAD = regwriteM & hit(rsD, writeregM);
      forwardBD = regwriteM & hit(rtD, writeregM);
      if (regwriteM && hit(rsE, writeregM))      forwardAE = 2'b10;
      else if (regwriteW && hit(rsE, writeregW)) forwardAE = 2'b01;
      if (regwriteM && hit(rtE, writeregM))      forwardBE = 2'b10;
      else if (regwriteW && hit(rtE, writeregW)) forwardBE = 2'b01;
      mdbusy = md_go | (state_q == StBusy);
      if (mdbusy) begin
        // Freeze the whole front end; a held instruction must not be flushed.
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
      end else begin
        stallF = lwstall | brstall;
        stallD = lwstall | brstall;
        flushE = lwstall | brstall;
      end
    end
  end

  // Mult/div sequencer: the IDLE launch cycle is busy cycle 1, the counter
  // covers the remaining MD_LAT-1, then DONE blocks a retrigger for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mdstartE) begin
            state_q <= StBusy;
            cnt_q   <= 4'(MD_LAT - 1);
          end
        end
        StBusy: begin
          if (cnt_q <= 4'd1) begin
            state_q <= StDone;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: per-cycle behavioural model plus directed literal checks.
module tb_hazard_unit;

  localparam int MD_LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       branchD, regwriteE, memtoregE, mdstartE;
  logic       regwriteM, memtoregM, regwriteW;
  logic       stallF, stallD, stallE, flushE, forwardAD, forwardBD, mdbusy;
  logic [1:0] forwardAE, forwardBE;

  int total = 0;
  int bad   = 0;

  hazard_unit #(.MD_LAT(MD_LAT)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .mdstartE(mdstartE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .mdbusy(mdbusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // md_left: busy cycles still owed after the current one; md_cool: one-cycle
  // lockout after a busy run finishes.
  int md_left = 0;
  bit md_cool = 1'b0;

  function automatic bit dep(input logic [4:0] src, input logic [4:0] dst, input logic wr);
    return wr && src != 0 && src == dst;
  endfunction

  function automatic int fwd_e(input logic [4:0] src);
    if (dep(src, writeregM, regwriteM)) return 2;
    if (dep(src, writeregW, regwriteW)) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      md_left = 0;
      md_cool = 1'b0;
    end else if (md_left > 0) begin
      md_left = md_left - 1;
      if (md_left == 0) md_cool = 1'b1;
    end else if (md_cool) begin
      md_cool = 1'b0;
    end else if (mdstartE) begin
      md_left = MD_LAT - 1;
    end
  end

  always @(negedge clk) begin
    bit busy, hz;
    busy = !reset && (md_left > 0 || (!md_cool && mdstartE));
    hz = (dep(rsD, writeregE, memtoregE) || dep(rtD, writeregE, memtoregE)) ||
         (branchD && (dep(rsD, writeregE, regwriteE) || dep(rtD, writeregE, regwriteE) ||
                      dep(rsD, writeregM, memtoregM) || dep(rtD, writeregM, memtoregM)));
    chk("m_mdbusy", int'(mdbusy), int'(busy));
    chk("m_stallF", int'(stallF), reset ? 0 : int'(busy || hz));
    chk("m_stallD", int'(stallD), reset ? 0 : int'(busy || hz));
    chk("m_stallE", int'(stallE), int'(busy));
    chk("m_flushE", int'(flushE), reset ? 1 : int'(!busy && hz));
    chk("m_fwdAE", int'(forwardAE), reset ? 0 : fwd_e(rsE));
    chk("m_fwdBE", int'(forwardBE), reset ? 0 : fwd_e(rtE));
    chk("m_fwdAD", int'(forwardAD), reset ? 0 : int'(dep(rsD, writeregM, regwriteM)));
    chk("m_fwdBD", int'(forwardBD), reset ? 0 : int'(dep(rtD, writeregM, regwriteM)));
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    branchD = 0; regwriteE = 0; memtoregE = 0; mdstartE = 0;
    regwriteM = 0; memtoregM = 0; regwriteW = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    chk("rst_flushE", int'(flushE), 1);
    chk("rst_mdbusy", int'(mdbusy), 0);
    chk("rst_stallF", int'(stallF), 0);
    next();
    reset = 1'b0;

    // M-stage bypass wins over W.
    regwriteM = 1; writeregM = 8; regwriteW = 1; writeregW = 8; rsE = 8; rtE = 8;
    @(negedge clk);
    chk("fwdAE_M", int'(forwardAE), 2);
    chk("fwdBE_M", int'(forwardBE), 2);
    next();
    regwriteM = 0;
    @(negedge clk);
    chk("fwdAE_W", int'(forwardAE), 1);
    next();
    regwriteM = 1; writeregM = 0; writeregW = 0; rsE = 0; rtE = 0;
    @(negedge clk);
    chk("fwdAE_r0", int'(forwardAE), 0);
    next();
    writeregM = 3; rsD = 3;
    @(negedge clk);
    chk("fwdAD", int'(forwardAD), 1);
    next();

    // Load-use stall.
    clear_inputs();
    memtoregE = 1; writeregE = 5; rtD = 5;
    @(negedge clk);
    chk("lw_stallF", int'(stallF), 1);
    chk("lw_flushE", int'(flushE), 1);
    chk("lw_stallE", int'(stallE), 0);
    next();
    rtD = 6;
    @(negedge clk);
    chk("nolw_stallF", int'(stallF), 0);
    chk("nolw_flushE", int'(flushE), 0);
    next();

    // Branch waiting on a load in M.
    clear_inputs();
    branchD = 1; memtoregM = 1; writeregM = 9; rsD = 9;
    @(negedge clk);
    chk("br_stallF", int'(stallF), 1);
    chk("br_stallD", int'(stallD), 1);
    chk("br_flushE", int'(flushE), 1);
    next();

    // mdstartE held: 4 busy, 1 DONE, then immediate relaunch.
    clear_inputs();
    mdstartE = 1;
    for (int i = 0; i < MD_LAT; i++) begin
      @(negedge clk);
      chk("md_busy", int'(mdbusy), 1);
      chk("md_stallE", int'(stallE), 1);
      next();
    end
    @(negedge clk);
    chk("md_done_busy", int'(mdbusy), 0);
    chk("md_done_stallE", int'(stallE), 0);
    next();
    @(negedge clk);
    chk("md_relaunch", int'(mdbusy), 1);
    next();
    mdstartE = 0;
    repeat (MD_LAT + 1) next();

    // Load-use hazard is overridden while busy, then takes effect.
    mdstartE = 1; memtoregE = 1; writeregE = 5; rtD = 5;
    @(negedge clk);
    chk("ovr_flushE", int'(flushE), 0);
    chk("ovr_stallF", int'(stallF), 1);
    next();
    mdstartE = 0;
    repeat (MD_LAT - 1) next();
    @(negedge clk);
    chk("after_flushE", int'(flushE), 1);
    chk("after_stallE", int'(stallE), 0);
    next();
    clear_inputs();
    next();

    // Reset on the second busy cycle.
    mdstartE = 1;
    @(negedge clk);
    chk("pre_rst_busy", int'(mdbusy), 1);
    next();
    reset = 1;
    @(negedge clk);
    chk("midrst_flushE", int'(flushE), 1);
    chk("midrst_mdbusy", int'(mdbusy), 0);
    next();
    reset = 0;
    for (int i = 0; i < MD_LAT; i++) begin
      @(negedge clk);
      chk("rerun_busy", int'(mdbusy), 1);
      next();
      mdstartE = 0;
    end
    @(negedge clk);
    chk("rerun_end", int'(mdbusy), 0);
    next();
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
